// File: rtl/board_input_ctrl_pkg.sv
// Shared encodings for the board-input front end.
package board_input_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_STEP = 2'b01,
        MODE_RUN  = 2'b10
    } mode_t;

endpackage

// File: rtl/board_input_ctrl_debounce_filter.sv
// Two-flop synchroniser, debounce counter and rising-edge press detector
// for one asynchronous board input.
module debounce_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync0    <= raw;
            sync1    <= sync0;
            stable_d <= stable;
            // Any return to the stable level restarts the count.
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = stable & ~stable_d;

endmodule

// File: rtl/board_input_ctrl.sv
// Board-input front end: debounced buttons/switches and the HALT/STEP/RUN
// state machine that issues one-cycle CPU clock enables.
module board_input_ctrl
    import board_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned RUN_DIV_BIT     = 21,
    parameter int unsigned NUM_SW          = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              btn_step,
    input  logic              btn_mode,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_db,
    output logic [1:0]        mode,
    output logic              step_pulse,
    output logic              cpu_ce
);

    logic                   step_press;
    logic                   mode_press;
    logic                   step_lvl_unused;
    logic                   mode_lvl_unused;
    logic [NUM_SW-1:0]      sw_press_unused;
    mode_t                  mode_q;
    logic [RUN_DIV_BIT-1:0] run_cnt;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_step (
        .clock(clock), .resetn(resetn), .raw(btn_step),
        .stable(step_lvl_unused), .press(step_press)
    );

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_mode (
        .clock(clock), .resetn(resetn), .raw(btn_mode),
        .stable(mode_lvl_unused), .press(mode_press)
    );

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sw (
            .clock(clock), .resetn(resetn), .raw(sw_raw[i]),
            .stable(sw_db[i]), .press(sw_press_unused[i])
        );
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            mode_q     <= MODE_HALT;
            step_pulse <= 1'b0;
            cpu_ce     <= 1'b0;
            run_cnt    <= '0;
        end else begin
            step_pulse <= 1'b0;
            cpu_ce     <= 1'b0;
            // A mode press takes priority over a step press or a divider wrap.
            case (mode_q)
                MODE_HALT: begin
                    if (mode_press) mode_q <= MODE_STEP;
                end
                MODE_STEP: begin
                    if (mode_press) begin
                        mode_q  <= MODE_RUN;
                        run_cnt <= '0;
                    end else if (step_press) begin
                        step_pulse <= 1'b1;
                        cpu_ce     <= 1'b1;
                    end
                end
                MODE_RUN: begin
                    if (mode_press) begin
                        mode_q <= MODE_HALT;
                    end else begin
                        run_cnt <= run_cnt + RUN_DIV_BIT'(1);
                        if (run_cnt == '1) cpu_ce <= 1'b1;
                    end
                end
                default: mode_q <= MODE_HALT;
            endcase
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_board_input_ctrl.sv
// Directed, table-driven bench for board_input_ctrl with short debounce/divider.
module tb_board_input_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       btn_step = 1'b1;
    logic       btn_mode = 1'b1;
    logic [7:0] sw_raw = 8'hFF;
    logic [7:0] sw_db;
    logic [1:0] mode;
    logic       step_pulse;
    logic       cpu_ce;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    board_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3),
        .RUN_DIV_BIT(3),
        .NUM_SW(8)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .btn_step(btn_step),
        .btn_mode(btn_mode),
        .sw_raw(sw_raw),
        .sw_db(sw_db),
        .mode(mode),
        .step_pulse(step_pulse),
        .cpu_ce(cpu_ce)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst_n;
        logic       bs;
        logic       bm;
        logic [7:0] sw;
        logic [7:0] e_sw;
        logic [1:0] e_mode;
        logic       e_sp;
        logic       e_ce;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input int unsigned reps, input logic rst_n, input logic bs,
                                input logic bm, input logic [7:0] sw, input logic [7:0] e_sw,
                                input logic [1:0] e_mode, input logic e_sp, input logic e_ce);
        vec_t v;
        v = '{rst_n, bs, bm, sw, e_sw, e_mode, e_sp, e_ce};
        for (int unsigned k = 0; k < reps; k++) vq.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] e_sw, input logic [1:0] e_mode,
                         input logic e_sp, input logic e_ce);
        n_vec++;
        if ({sw_db, mode, step_pulse, cpu_ce} !== {e_sw, e_mode, e_sp, e_ce}) begin
            n_bad++;
            $display("FAIL %s: got sw_db=%h mode=%b step_pulse=%b cpu_ce=%b, want sw_db=%h mode=%b step_pulse=%b cpu_ce=%b",
                     name, sw_db, mode, step_pulse, cpu_ce, e_sw, e_mode, e_sp, e_ce);
        end
    endtask

    // Drive buttons for one cycle, then check outputs with switches settled at A5.
    task automatic cyc(input string name, input int t, input logic bs, input logic bm,
                       input logic [1:0] e_mode, input logic e_sp, input logic e_ce);
        btn_step = bs;
        btn_mode = bm;
        tick();
        check($sformatf("%s t=%0d", name, t), 8'hA5, e_mode, e_sp, e_ce);
    endtask

    initial begin
        // Reset with all inputs high, then release: switches settle 6 cycles later,
        // both buttons press together in HALT so only the mode advances.
        add(3, 0, 1, 1, 8'hFF, 8'h00, 2'b00, 0, 0);
        add(5, 1, 1, 1, 8'hFF, 8'h00, 2'b00, 0, 0);
        add(1, 1, 1, 1, 8'hFF, 8'hFF, 2'b00, 0, 0);
        add(1, 1, 1, 1, 8'hFF, 8'hFF, 2'b01, 0, 0);
        // Clean reset with buttons low.
        add(2, 0, 0, 0, 8'h5A, 8'h00, 2'b00, 0, 0);
        add(5, 1, 0, 0, 8'h5A, 8'h00, 2'b00, 0, 0);
        add(1, 1, 0, 0, 8'h5A, 8'h5A, 2'b00, 0, 0);
        // Bouncing mode button never qualifies.
        add(1, 1, 0, 1, 8'h5A, 8'h5A, 2'b00, 0, 0);
        add(1, 1, 0, 0, 8'h5A, 8'h5A, 2'b00, 0, 0);
        add(1, 1, 0, 1, 8'h5A, 8'h5A, 2'b00, 0, 0);
        add(8, 1, 0, 0, 8'h5A, 8'h5A, 2'b00, 0, 0);
        // Clean mode press held 10 cycles: mode changes on the 7th.
        add(6, 1, 0, 1, 8'h5A, 8'h5A, 2'b00, 0, 0);
        add(4, 1, 0, 1, 8'h5A, 8'h5A, 2'b01, 0, 0);
        // Release generates nothing; switches change to A5.
        add(5, 1, 0, 0, 8'hA5, 8'h5A, 2'b01, 0, 0);
        add(3, 1, 0, 0, 8'hA5, 8'hA5, 2'b01, 0, 0);

        foreach (vq[i]) begin
            resetn   = vq[i].rst_n;
            btn_step = vq[i].bs;
            btn_mode = vq[i].bm;
            sw_raw   = vq[i].sw;
            tick();
            check($sformatf("vec%0d", i), vq[i].e_sw, vq[i].e_mode, vq[i].e_sp, vq[i].e_ce);
        end

        // STEP: held step gives exactly one pulse, on the 7th cycle; then a second press.
        for (int t = 1; t <= 20; t++) cyc("step1", t, 1, 0, 2'b01, t == 7, t == 7);
        for (int t = 1; t <= 10; t++) cyc("step1_rel", t, 0, 0, 2'b01, 0, 0);
        for (int t = 1; t <= 8;  t++) cyc("step2", t, 1, 0, 2'b01, t == 7, t == 7);
        for (int t = 1; t <= 10; t++) cyc("step2_rel", t, 0, 0, 2'b01, 0, 0);

        // RUN: entry at t=7, cpu_ce at 15/23/31; step ignored; leaving at the t=39 wrap
        // suppresses that enable; step ignored in HALT afterwards.
        for (int t = 1; t <= 60; t++) begin
            logic       bm;
            logic       bs;
            logic [1:0] em;
            bm = (t <= 9) || (t >= 33 && t <= 42);
            bs = (t >= 12 && t <= 23) || (t >= 45 && t <= 54);
            em = (t < 7) ? 2'b01 : (t < 39) ? 2'b10 : 2'b00;
            cyc("run", t, bs, bm, em, 0, (t == 15) || (t == 23) || (t == 31));
        end

        // HALT -> STEP.
        for (int t = 1; t <= 8; t++) cyc("to_step", t, 0, 1, (t < 7) ? 2'b00 : 2'b01, 0, 0);
        for (int t = 1; t <= 8; t++) cyc("to_step_rel", t, 0, 0, 2'b01, 0, 0);

        // Coincident mode and step presses in STEP: mode wins, no step.
        for (int t = 1; t <= 12; t++)
            cyc("both", t, t <= 8, t <= 8, (t < 7) ? 2'b01 : 2'b10, 0, 0);

        // Reset mid-RUN clears everything on the next edge.
        resetn = 1'b0;
        tick();
        check("reset_mid_run", 8'h00, 2'b00, 0, 0);
        resetn = 1'b1;
        tick();
        check("after_reset", 8'h00, 2'b00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
